// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and PC fault helper for pipeline stage registers
package pipe_pkg;

  localparam int EXC_NONE = 0;
  localparam int EXC_ADEL = 4;
  localparam int EXC_ADES = 5;
  localparam int EXC_RI   = 10;
  localparam int EXC_OV   = 12;

  localparam logic [31:0] TEXT_LO = 32'h0000_3000;
  localparam logic [31:0] TEXT_HI = 32'h0000_6FFC;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_FLUSH_PC = 32'h0000_4180;

  // Instruction fetch address is bad if misaligned or outside the text segment.
  function automatic logic pc_fault(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < TEXT_LO) || (pc > TEXT_HI);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// rtl/pipe_stage_reg_if.sv - signal bundle between a pipeline stage and its stage register
interface pipe_stage_reg_if #(
  parameter int DATA_W = 32,
  parameter int EXC_W  = 5,
  parameter int CNT_W  = 8
);
  logic              stopen;
  logic              flush;
  logic              bubble;
  logic              valid_in;
  logic [31:0]       PC_in;
  logic [DATA_W-1:0] data_in;
  logic [EXC_W-1:0]  exc_in;
  logic              bd_in;
  logic              valid_out;
  logic [31:0]       PC_out;
  logic [DATA_W-1:0] data_out;
  logic [EXC_W-1:0]  exc_out;
  logic              bd_out;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output stopen, flush, bubble, valid_in, PC_in, data_in, exc_in, bd_in,
    input  valid_out, PC_out, data_out, exc_out, bd_out, stall_cnt
  );

  modport slave (
    input  stopen, flush, bubble, valid_in, PC_in, data_in, exc_in, bd_in,
    output valid_out, PC_out, data_out, exc_out, bd_out, stall_cnt
  );
endinterface

// File: rtl/pipe_exc_check.sv
// rtl/pipe_exc_check.sv - fetch-address fault detection merged with upstream exception
module pipe_exc_check
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXC_W  = 5
) (
  input  logic              valid_in,
  input  logic [31:0]       pc,
  input  logic [EXC_W-1:0]  exc_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [EXC_W-1:0]  exc,
  output logic [DATA_W-1:0] data
);
  logic fault;

  // An earlier exception always wins; only a clean, real instruction gets tagged AdEL.
  always_comb begin
    fault = valid_in && (exc_in == EXC_W'(EXC_NONE)) && pc_fault(pc);
    exc   = exc_in;
    data  = data_in;
    if (fault) begin
      exc  = EXC_W'(EXC_ADEL);
      data = '0;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with stall, bubble, flush and stall counter
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DATA_W   = 32,
  parameter int          EXC_W    = 5,
  parameter int          CNT_W    = 8,
  parameter bit          CHECK_PC = 1'b0,
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] FLUSH_PC = DEF_FLUSH_PC
) (
  input logic            clk,
  input logic            reset,
  pipe_stage_reg_if.slave bus
);
  logic [EXC_W-1:0]  exc_ld;
  logic [DATA_W-1:0] data_ld;

  logic              valid_q;
  logic [31:0]       pc_q;
  logic [DATA_W-1:0] data_q;
  logic [EXC_W-1:0]  exc_q;
  logic              bd_q;
  logic [CNT_W-1:0]  cnt_q;

  generate
    if (CHECK_PC) begin : g_check
      pipe_exc_check #(
        .DATA_W (DATA_W),
        .EXC_W  (EXC_W)
      ) u_exc_check (
        .valid_in (bus.valid_in),
        .pc       (bus.PC_in),
        .exc_in   (bus.exc_in),
        .data_in  (bus.data_in),
        .exc      (exc_ld),
        .data     (data_ld)
      );
    end else begin : g_nocheck
      assign exc_ld  = bus.exc_in;
      assign data_ld = bus.data_in;
    end
  endgenerate

  // Stage contents: reset > flush > stall hold > bubble (keeps PC/bd for EPC) > load.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      data_q  <= '0;
      exc_q   <= '0;
      bd_q    <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
      pc_q    <= FLUSH_PC;
      data_q  <= '0;
      exc_q   <= '0;
      bd_q    <= 1'b0;
    end else if (bus.stopen) begin
      valid_q <= valid_q;
    end else if (bus.bubble) begin
      valid_q <= 1'b0;
      pc_q    <= bus.PC_in;
      data_q  <= '0;
      exc_q   <= '0;
      bd_q    <= bus.bd_in;
    end else begin
      valid_q <= bus.valid_in;
      pc_q    <= bus.PC_in;
      data_q  <= data_ld;
      exc_q   <= exc_ld;
      bd_q    <= bus.bd_in;
    end
  end

  // Consecutive stall cycles, saturating; any non-stall or flush edge clears it.
  always_ff @(posedge clk) begin
    if (reset || bus.flush || !bus.stopen) begin
      cnt_q <= '0;
    end else if (cnt_q != {CNT_W{1'b1}}) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.PC_out    = pc_q;
  assign bus.data_out  = data_q;
  assign bus.exc_out   = exc_q;
  assign bus.bd_out    = bd_q;
  assign bus.stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed vector bench for pipe_stage_reg
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  // ifa: CHECK_PC=1, CNT_W=2.  ifb: CHECK_PC=0, CNT_W=8, same stimulus.
  pipe_stage_reg_if #(.DATA_W(32), .EXC_W(5), .CNT_W(2)) ifa ();
  pipe_stage_reg_if #(.DATA_W(32), .EXC_W(5), .CNT_W(8)) ifb ();

  assign ifb.stopen   = ifa.stopen;
  assign ifb.flush    = ifa.flush;
  assign ifb.bubble   = ifa.bubble;
  assign ifb.valid_in = ifa.valid_in;
  assign ifb.PC_in    = ifa.PC_in;
  assign ifb.data_in  = ifa.data_in;
  assign ifb.exc_in   = ifa.exc_in;
  assign ifb.bd_in    = ifa.bd_in;

  pipe_stage_reg #(.DATA_W(32), .EXC_W(5), .CNT_W(2), .CHECK_PC(1'b1)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa)
  );

  pipe_stage_reg #(.DATA_W(32), .EXC_W(5), .CNT_W(8), .CHECK_PC(1'b0)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb)
  );

  typedef struct {
    logic        rst, stopen, flush, bubble, vin, bd;
    logic [31:0] pc, data;
    logic [4:0]  exc;
    logic        ev, ebd;
    logic [31:0] epc, edata;
    logic [4:0]  eexc;
    logic [1:0]  ecnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(input logic rst, stopen, flush, bubble, vin,
                              input logic [31:0] pc, data, input logic [4:0] exc,
                              input logic bd, ev, input logic [31:0] epc, edata,
                              input logic [4:0] eexc, input logic ebd,
                              input logic [1:0] ecnt);
    vec_t v;
    v.rst = rst; v.stopen = stopen; v.flush = flush; v.bubble = bubble; v.vin = vin;
    v.pc = pc; v.data = data; v.exc = exc; v.bd = bd;
    v.ev = ev; v.epc = epc; v.edata = edata; v.eexc = eexc; v.ebd = ebd; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    reset        = v.rst;
    ifa.stopen   = v.stopen;
    ifa.flush    = v.flush;
    ifa.bubble   = v.bubble;
    ifa.valid_in = v.vin;
    ifa.PC_in    = v.pc;
    ifa.data_in  = v.data;
    ifa.exc_in   = v.exc;
    ifa.bd_in    = v.bd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            rst st fl bu vi pc            data          exc bd | ev epc           edata         eexc ebd cnt
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0000_0000, 32'h0,        0, 0, 0, 32'h3000, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0000_3004, 32'hDEAD_BEEF, 0, 0, 1, 32'h3004, 32'hDEAD_BEEF, 0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0000_3008, 32'h1111_1111, 0, 1, 1, 32'h3004, 32'hDEAD_BEEF, 0, 0, 1));
    vecs.push_back(mk(0, 1, 0, 0, 0, 32'h0000_300C, 32'h2222_2222, 3, 0, 1, 32'h3004, 32'hDEAD_BEEF, 0, 0, 2));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0000_3010, 32'h3333_3333, 0, 1, 1, 32'h3004, 32'hDEAD_BEEF, 0, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0000_3008, 32'h1234_5678, 0, 0, 1, 32'h3008, 32'h1234_5678, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 32'h0000_3010, 32'h0000_AAAA, 0, 1, 0, 32'h3010, 32'h0,        0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0000_3014, 32'h0000_BBBB, 0, 0, 0, 32'h3010, 32'h0,        0, 1, 1));
    vecs.push_back(mk(0, 1, 1, 0, 1, 32'h0000_3020, 32'h0000_CCCC, 7, 1, 0, 32'h4180, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0000_3002, 32'h0000_CAFE, 0, 0, 1, 32'h3002, 32'h0,        4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0000_7000, 32'h0000_5555, 0, 0, 1, 32'h7000, 32'h0,        4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0000_3002, 32'h0000_0077, 12, 1, 1, 32'h3002, 32'h77,      12, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0000_6FFC, 32'h0000_0088, 0, 0, 1, 32'h6FFC, 32'h88,       0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h0000_2FFC, 32'h0000_0066, 0, 0, 1, 32'h2FFC, 32'h0,        4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 32'h0000_3002, 32'h0000_0099, 0, 0, 0, 32'h3002, 32'h99,       0, 0, 0));
    for (int k = 1; k <= 6; k++) begin
      vecs.push_back(mk(0, 1, 0, 0, 1, 32'h0000_3100 + 32'(k), 32'h0000_1000 + 32'(k), 0, 1,
                        0, 32'h3002, 32'h99, 0, 0, (k > 3) ? 2'd3 : 2'(k)));
    end
    vecs.push_back(mk(1, 1, 0, 0, 1, 32'h0000_3200, 32'h0000_0123, 0, 1, 0, 32'h3000, 32'h0,        0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 32'h0000_3204, 32'h0000_0456, 0, 1, 0, 32'h3000, 32'h0,        0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 0, 1, 32'h0000_3208, 32'h0000_0789, 2, 1, 0, 32'h4180, 32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 1, 32'h0000_320C, 32'h0000_0abc, 0, 1, 0, 32'h3000, 32'h0,        0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      step();
      chk($sformatf("v%0d valid_out", i), 32'(ifa.valid_out), 32'(vecs[i].ev));
      chk($sformatf("v%0d PC_out", i),    ifa.PC_out,          vecs[i].epc);
      chk($sformatf("v%0d data_out", i),  ifa.data_out,        vecs[i].edata);
      chk($sformatf("v%0d exc_out", i),   32'(ifa.exc_out),    32'(vecs[i].eexc));
      chk($sformatf("v%0d bd_out", i),    32'(ifa.bd_out),     32'(vecs[i].ebd));
      chk($sformatf("v%0d stall_cnt", i), 32'(ifa.stall_cnt), 32'(vecs[i].ecnt));
      if (i == 9) begin
        chk("nocheck exc_out", 32'(ifb.exc_out), 32'd0);
        chk("nocheck data_out", ifb.data_out, 32'h0000_CAFE);
      end
      if (i == 20) chk("wide stall_cnt after 6", 32'(ifb.stall_cnt), 32'd6);
    end

    // Long stall: 8-bit counter saturates at 255 while the 2-bit one sits at 3.
    drive(mk(0, 1, 0, 0, 1, 32'h0000_3300, 32'h0000_0abc, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 300; k++) begin
      step();
      if (k == 254) chk("wide stall_cnt 254", 32'(ifb.stall_cnt), 32'd254);
      if (k == 255) chk("wide stall_cnt 255", 32'(ifb.stall_cnt), 32'd255);
    end
    chk("wide stall_cnt sat", 32'(ifb.stall_cnt), 32'd255);
    chk("narrow stall_cnt sat", 32'(ifa.stall_cnt), 32'd3);
    chk("long stall PC hold", ifb.PC_out, 32'h3000);

    ifa.stopen = 1'b0;
    step();
    chk("release stall_cnt", 32'(ifb.stall_cnt), 32'd0);
    chk("release PC_out", ifb.PC_out, 32'h3300);
    chk("release data_out", ifb.data_out, 32'h0000_0abc);
    chk("release valid_out", 32'(ifb.valid_out), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the five-stage MIPS32 core. It replaces the single-field PC registers between stages (F/D, D/E, E/M, M/W) with one reusable block. The block carries the PC, a generic payload, an exception code and a delay-slot flag, plus a valid bit. It supports stall-hold, bubble insertion with PC retention for EPC, flush, optional fetch-address exception tagging, and a saturating stall-cycle counter.

## Interface
Parameters:
- DATA_W, 32: payload width (instruction, operands, control bundle).
- EXC_W, 5: exception-code width (CP0 Cause.ExcCode).
- CNT_W, 8: stall counter width.
- CHECK_PC, 0: when 1, tag PC_in alignment/range faults with AdEL.
- RESET_PC, 32'h0000_3000: PC_out value after reset.
- FLUSH_PC, 32'h0000_4180: PC_out value after flush (handler entry).

Ports:
- clk, in, 1: clock; all state updates on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- stopen, in, 1: stall; hold all registers.
- flush, in, 1: exception/eret flush; kill stage contents.
- bubble, in, 1: insert NOP; upstream is stalled.
- valid_in, in, 1: upstream slot holds a real instruction.
- PC_in, in, 32: upstream PC.
- data_in, in, DATA_W: upstream payload.
- exc_in, in, EXC_W: upstream exception code; 0 = none.
- bd_in, in, 1: upstream instruction is in a delay slot.
- valid_out, out, 1: registered valid.
- PC_out, out, 32: registered PC.
- data_out, out, DATA_W: registered payload.
- exc_out, out, EXC_W: registered exception code.
- bd_out, out, 1: registered delay-slot flag.
- stall_cnt, out, CNT_W: consecutive stall cycles, saturating.

## Operation
- Priority per edge: reset > flush > stopen > bubble > load.
- reset: valid_out=0, PC_out=RESET_PC, data_out=0, exc_out=0, bd_out=0, stall_cnt=0.
- flush: valid_out=0, PC_out=FLUSH_PC, data_out=0, exc_out=0, bd_out=0. Flush overrides a simultaneous stopen.
- stopen (no flush): all outputs hold. stall_cnt increments and saturates at 2^CNT_W−1.
- bubble (no stopen/flush): valid_out=0, data_out=0, exc_out=0. PC_out<=PC_in and bd_out<=bd_in are retained, so CP0 can compute EPC from a bubble.
- load: every field <= its input; valid_out<=valid_in.
- Exception tagging (CHECK_PC=1, load only):
  - Applies when exc_in==0 and valid_in=1.
  - Fault condition: PC_in[1:0]!=0, or PC_in outside [32'h3000, 32'h6FFC].
  - On fault: exc_out<=4 (AdEL), data_out<=0.
  - A nonzero exc_in always wins; an earlier exception is never overwritten.
- stall_cnt: cleared to 0 on any edge with stopen=0 or flush=1.

## Timing
- One-cycle latency: inputs sampled at edge N appear on outputs after edge N.
- All outputs are registered. There is no combinational input-to-output path.
- stopen held for k cycles gives stall_cnt=min(k, 2^CNT_W−1) after the k-th edge.
- reset asserted mid-stall or mid-flush takes effect on that edge and overrides everything.
- bubble and stopen together: the block holds, and bubble is ignored.

## Structure
- Shared package pipe_pkg:
  - EXC_NONE=0, EXC_ADEL=4, EXC_ADES=5, EXC_RI=10, EXC_OV=12.
  - TEXT_LO=32'h3000, TEXT_HI=32'h6FFC.
  - RESET_PC and FLUSH_PC constants.
- Sub-module pipe_exc_check: combinational PC fault detection plus exception-priority merge. It is instantiated only under CHECK_PC.
- One instance per stage boundary. DATA_W is sized to each stage's control bundle.

## Test plan
- Load, stall, reset:
  - reset 1 cycle, then PC_in=32'h3004, data_in=32'hDEAD_BEEF, valid_in=1 -> next cycle PC_out=32'h3004, data_out=32'hDEAD_BEEF, valid_out=1.
  - Then stopen=1 for 3 cycles with changing inputs -> outputs frozen, stall_cnt=1,2,3.
  - stopen=0 -> outputs load the new inputs, stall_cnt=0.
- Bubble: bubble=1, PC_in=32'h3010, bd_in=1 -> valid_out=0, data_out=0, exc_out=0, PC_out=32'h3010, bd_out=1.
- Flush vs stall: flush=1 and stopen=1 together -> PC_out=32'h4180, valid_out=0, all fields 0, stall_cnt=0.
- Exception tagging (CHECK_PC=1):
  - PC_in=32'h3002, exc_in=0 -> exc_out=4, data_out=0.
  - PC_in=32'h7000 -> exc_out=4.
  - PC_in=32'h3002, exc_in=12 -> exc_out=12.
- Counter saturation (CNT_W=2): stopen held 6 cycles -> stall_cnt sequence 1,2,3,3,3,3.
- Reset mid-stall: reset=1 while stopen=1 -> PC_out=32'h3000, valid_out=0, stall_cnt=0 on that edge.
